// File: rtl/seq_divider_8bit.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_op port for two's-complement operands.
module seq_divider_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
   input  logic             signed_op,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dq;
   logic [WIDTH-1:0] r_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remo;
   logic             r_dbz;

   logic             w_neg_a;
   logic             w_neg_b;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_q_fin;
   logic [WIDTH-1:0] w_r_fin;

   // The core always divides magnitudes; signs are reapplied on the last step.
`ifdef SEQ_DIVIDER_SIGNED_EN
   assign w_neg_a = signed_op & dividend[WIDTH-1];
   assign w_neg_b = signed_op & divisor[WIDTH-1];
`else
   assign w_neg_a = 1'b0;
   assign w_neg_b = 1'b0;
`endif
   assign w_mag_a = w_neg_a ? -dividend : dividend;
   assign w_mag_b = w_neg_b ? -divisor : divisor;

   assign w_sh      = {r_rem, r_dq[WIDTH-1]};
   assign w_trial   = w_sh - {1'b0, r_div};
   assign w_rem_nxt = w_trial[WIDTH] ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign w_q_nxt   = {r_dq[WIDTH-2:0], ~w_trial[WIDTH]};
   assign w_q_fin   = r_neg_q ? -w_q_nxt : w_q_nxt;
   assign w_r_fin   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

   assign busy        = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign quotient    = r_quot;
   assign remainder   = r_remo;
   assign div_by_zero = r_dbz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dq    <= '0;
         r_div   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_quot  <= '0;
         r_remo  <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_rem <= w_rem_nxt;
               r_dq  <= w_q_nxt;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_DONE;
                  r_quot  <= w_q_fin;
                  r_remo  <= w_r_fin;
               end
            end
            default: begin
               // IDLE and DONE both accept a new request.
               if (start) begin
                  if (divisor == '0) begin
                     r_state <= S_DONE;
                     r_quot  <= '1;
                     r_remo  <= dividend;
                     r_dbz   <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                     r_dq    <= w_mag_a;
                     r_div   <= w_mag_b;
                     r_rem   <= '0;
                     r_cnt   <= CW'(WIDTH);
                     r_neg_q <= w_neg_a ^ w_neg_b;
                     r_neg_r <= w_neg_a;
                     r_dbz   <= 1'b0;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Scoreboard bench for seq_divider_8bit: expected results queued at issue,
// compared on every done pulse.
module tb_seq_divider_8bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [7:0] divisor = '0;
   logic       signed_op = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int n_chk = 0;
   int n_err = 0;
   int n_done = 0;
   int n_exp = 0;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
   } exp_t;

   exp_t sb[$];

   seq_divider_8bit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
      .signed_op  (signed_op),
`endif
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input logic sop);
      exp_t e;
      int   da;
      int   db;
      if (b == 8'd0) begin
         e.q = 8'hFF;
         e.r = a;
         e.z = 1'b1;
      end else if (sop) begin
         da  = int'($signed(a));
         db  = int'($signed(b));
         e.q = 8'(da / db);
         e.r = 8'(da % db);
         e.z = 1'b0;
      end else begin
         e.q = a / b;
         e.r = a % b;
         e.z = 1'b0;
      end
      return e;
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && done) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("quot", quotient, e.q);
            chk("rem", remainder, e.r);
            chk("dbz", div_by_zero, e.z);
            chk("busy_at_done", busy, 0);
         end
      end
   end

   // Drives a request at the current negedge and waits for its done pulse.
   // poke != 0 pulses a competing start with new operands on that cycle.
   task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                          input logic sop, input int poke);
      int lat;
      int bcnt;
      int exp_lat;
      lat = 0;
      bcnt = 0;
      exp_lat = (b == 8'd0) ? 1 : 9;
      dividend = a;
      divisor = b;
      signed_op = sop;
      start = 1'b1;
      sb.push_back(model(a, b, sop));
      n_exp++;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == 2 && b != 8'd0) chk("dbz_cleared", div_by_zero, 0);
         if (poke != 0 && i == poke) begin
            start = 1'b1;
            dividend = 8'd50;
            divisor = 8'd5;
         end
         if (poke != 0 && i == poke + 1) begin
            start = 1'b0;
            dividend = 8'd1;
            divisor = 8'd1;
         end
         if (busy) bcnt++;
         if (done) begin
            lat = i;
            break;
         end
      end
      chk("latency", lat, exp_lat);
      chk("busy_cycles", bcnt, exp_lat - 1);
   endtask

   initial begin : wdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic [7:0] a;
      logic [7:0] b;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quot", quotient, 0);
      chk("rst_rem", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_div(8'd200, 8'd7, 1'b0, 0);
      @(negedge clk);
      run_div(8'd5, 8'd0, 1'b0, 0);
      @(negedge clk);
      run_div(8'd9, 8'd3, 1'b0, 0);
      @(negedge clk);
      run_div(8'hFF, 8'd1, 1'b0, 0);
      @(negedge clk);
      run_div(8'd3, 8'd10, 1'b0, 0);
      run_div(8'd100, 8'd9, 1'b0, 0);
      run_div(8'd0, 8'd17, 1'b0, 0);
      run_div(8'd7, 8'd0, 1'b0, 0);
      run_div(8'd255, 8'd255, 1'b0, 0);
      @(negedge clk);

      run_div(8'd200, 8'd7, 1'b0, 3);
      repeat (3) @(negedge clk);
      chk("single_done", n_done, n_exp);

      dividend = 8'd200;
      divisor = 8'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_quot", quotient, 0);
      chk("mid_rst_rem", remainder, 0);
      chk("mid_rst_dbz", div_by_zero, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("no_done_after_rst", n_done, n_exp);
      run_div(8'd10, 8'd3, 1'b0, 0);
      @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         a = 8'($urandom_range(0, 255));
         b = (i % 6 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         run_div(a, b, 1'b0, 0);
         if (i % 2 == 0) @(negedge clk);
      end

`ifdef SEQ_DIVIDER_SIGNED_EN
      @(negedge clk);
      run_div(8'hF9, 8'h02, 1'b1, 0);
      run_div(8'h07, 8'hFE, 1'b1, 0);
      run_div(8'h80, 8'hFF, 1'b1, 0);
      run_div(8'hF9, 8'h00, 1'b1, 0);
      run_div(8'hF9, 8'h02, 1'b0, 0);
      for (int i = 0; i < 16; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(1, 255));
         run_div(a, b, 1'b1, 0);
      end
`endif

      repeat (4) @(negedge clk);
      chk("done_count", n_done, n_exp);
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
